// File: rtl/glb_load_sequencer.sv
// Sequences DRAM words into bias, ifmap and weight global buffers
// in a fixed order, with a registered SRAM write port.
//
// Ports:
//   clk, rst          single clock, synchronous active-high reset
//   start, load_mask  begin a sequence; bit0 bias, bit1 ifmap, bit2 weight
//   abort             return to idle, dropping the word taken this cycle
//   ready, data_in    DRAM word valid / DRAM word
//   data_req          a word is taken this cycle when ready is also high
//   *_wen, wr_addr,   registered SRAM write, one cycle after the word is taken
//   wr_data
//   busy, load_done   sequence in progress / one-cycle completion pulse
module glb_load_sequencer #(
  parameter int BIAS_WORDS   = 64,
  parameter int IFMAP_WORDS  = 16,
  parameter int WEIGHT_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  load_mask,
  input  logic        abort,
  input  logic        ready,
  input  logic [31:0] data_in,
  output logic        data_req,
  output logic        bias_wen,
  output logic        ifmap_wen,
  output logic        weight_wen,
  output logic [9:0]  wr_addr,
  output logic [31:0] wr_data,
  output logic        busy,
  output logic        load_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_BIAS,
    S_IFMAP,
    S_WEIGHT,
    S_DONE
  } state_t;

  localparam logic [9:0] B_LAST = 10'(BIAS_WORDS - 1);
  localparam logic [9:0] I_LAST = 10'(IFMAP_WORDS - 1);
  localparam logic [9:0] W_LAST = 10'(WEIGHT_WORDS - 1);

  state_t      state_q, state_d;
  logic [2:0]  mask_q, mask_d;
  logic [9:0]  cnt_q, cnt_d;
  logic [2:0]  wen_q, wen_d;
  logic [9:0]  addr_q, addr_d;
  logic [31:0] data_q, data_d;

  logic        accept;
  logic        last;

  // First enabled region in fixed order, or DONE if none remains.
  function automatic state_t pick(input logic [2:0] m);
    state_t s;
    if (m[0])      s = S_BIAS;
    else if (m[1]) s = S_IFMAP;
    else if (m[2]) s = S_WEIGHT;
    else           s = S_DONE;
    return s;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      mask_q  <= '0;
      cnt_q   <= '0;
      wen_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      cnt_q   <= cnt_d;
      wen_q   <= wen_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    mask_d   = mask_q;
    cnt_d    = cnt_q;
    wen_d    = '0;
    addr_d   = addr_q;
    data_d   = data_q;
    data_req = 1'b0;
    last     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        // start wins over a simultaneous abort here
        if (start) begin
          mask_d  = load_mask;
          cnt_d   = '0;
          state_d = pick(load_mask);
        end
      end
      S_BIAS: begin
        data_req = 1'b1;
        last     = (cnt_q == B_LAST);
      end
      S_IFMAP: begin
        data_req = 1'b1;
        last     = (cnt_q == I_LAST);
      end
      S_WEIGHT: begin
        data_req = 1'b1;
        last     = (cnt_q == W_LAST);
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    accept = data_req & ready;

    if (accept) begin
      if (last) begin
        cnt_d = '0;
        unique case (state_q)
          S_BIAS:  state_d = pick(mask_q & 3'b110);
          S_IFMAP: state_d = pick(mask_q & 3'b100);
          default: state_d = S_DONE;
        endcase
      end else begin
        cnt_d = cnt_q + 10'd1;
      end
      if (!abort) begin
        wen_d  = {state_q == S_WEIGHT,
                  state_q == S_IFMAP,
                  state_q == S_BIAS};
        addr_d = cnt_q;
        data_d = data_in;
      end
    end

    if (abort && state_q != S_IDLE) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end
  end

  assign bias_wen   = wen_q[0];
  assign ifmap_wen  = wen_q[1];
  assign weight_wen = wen_q[2];
  assign wr_addr    = addr_q;
  assign wr_data    = data_q;
  assign busy       = (state_q != S_IDLE);
  assign load_done  = (state_q == S_DONE);

endmodule

// File: tb/tb_glb_load_sequencer.sv
// Bench for glb_load_sequencer: queue-based reference model checked
// every cycle, plus hand-computed expectations for each scenario.
module tb_glb_load_sequencer;

  localparam int BW = 4;
  localparam int IW = 2;
  localparam int WW = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  load_mask = 3'b000;
  logic        abort = 1'b0;
  logic        ready = 1'b0;
  logic [31:0] data_in = 32'h0;
  logic        data_req, bias_wen, ifmap_wen, weight_wen;
  logic [9:0]  wr_addr;
  logic [31:0] wr_data;
  logic        busy, load_done;

  glb_load_sequencer #(
    .BIAS_WORDS  (BW),
    .IFMAP_WORDS (IW),
    .WEIGHT_WORDS(WW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .load_mask (load_mask),
    .abort     (abort),
    .ready     (ready),
    .data_in   (data_in),
    .data_req  (data_req),
    .bias_wen  (bias_wen),
    .ifmap_wen (ifmap_wen),
    .weight_wen(weight_wen),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .busy      (busy),
    .load_done (load_done)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference model: a sequence is a queue of (region, address)
  // slots; each taken word pops one slot and is written next cycle.
  int          m_ph = 0;
  int          q_reg[$];
  int          q_addr[$];
  bit          p_v = 0;
  int          p_reg = 0;
  logic [9:0]  l_addr = '0;
  logic [31:0] l_data = '0;
  int          words[3] = '{BW, IW, WW};

  int cyc = 0;
  int n_w[3] = '{0, 0, 0};
  int n_done = 0;
  int done_cyc = 0;

  task automatic advance();
    if (rst) begin
      m_ph = 0;
      q_reg.delete();
      q_addr.delete();
      p_v = 0;
      l_addr = '0;
      l_data = '0;
    end else begin
      p_v = 0;
      if (m_ph == 0) begin
        if (start) begin
          for (int r = 0; r < 3; r++)
            if (load_mask[r])
              for (int a = 0; a < words[r]; a++) begin
                q_reg.push_back(r);
                q_addr.push_back(a);
              end
          m_ph = (q_reg.size() > 0) ? 1 : 2;
        end
      end else if (m_ph == 2) begin
        m_ph = 0;
      end else if (abort) begin
        m_ph = 0;
        q_reg.delete();
        q_addr.delete();
      end else if (ready) begin
        p_v = 1;
        p_reg = q_reg.pop_front();
        l_addr = 10'(q_addr.pop_front());
        l_data = data_in;
        if (q_reg.size() == 0) m_ph = 2;
      end
    end
  endtask

  // Inputs change only at negedge+1, so at each negedge they still
  // hold what the DUT sampled at the preceding posedge.
  initial forever begin
    logic [63:0] e, a;
    @(negedge clk);
    cyc++;
    advance();
    e = {16'h0, m_ph == 1, p_v && p_reg == 0, p_v && p_reg == 1,
         p_v && p_reg == 2, m_ph != 0, m_ph == 2, l_addr, l_data};
    a = {16'h0, data_req, bias_wen, ifmap_wen, weight_wen,
         busy, load_done, wr_addr, wr_data};
    chk("outputs", a, e);
    if (bias_wen === 1'b1)   n_w[0]++;
    if (ifmap_wen === 1'b1)  n_w[1]++;
    if (weight_wen === 1'b1) n_w[2]++;
    if (load_done === 1'b1) begin
      n_done++;
      done_cyc = cyc;
    end
  end

  int dseq = 0;

  task automatic tick(input logic r, input logic s,
                      input logic [2:0] m,
                      input logic ab, input logic rd);
    @(negedge clk);
    #1;
    rst = r;
    start = s;
    load_mask = m;
    abort = ab;
    ready = rd;
    data_in = 32'hD000_0000 + 32'(dseq);
    dseq++;
  endtask

  int b0[3];
  int d0;
  int sc;

  task automatic snap();
    for (int i = 0; i < 3; i++) b0[i] = n_w[i];
    d0 = n_done;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    #1;
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_addr", 64'(wr_addr), 64'd0);

    // Full load, ready always high
    snap();
    tick(0, 1, 3'b111, 0, 1);
    sc = cyc;
    repeat (12) tick(0, 0, 3'b000, 0, 1);
    chk("full_latency", 64'(done_cyc - sc + 1), 64'd11);
    chk("full_bias", 64'(n_w[0] - b0[0]), 64'd4);
    chk("full_ifmap", 64'(n_w[1] - b0[1]), 64'd2);
    chk("full_weight", 64'(n_w[2] - b0[2]), 64'd3);
    chk("full_done", 64'(n_done - d0), 64'd1);

    // Stall in bias region
    snap();
    tick(0, 1, 3'b001, 0, 0);
    tick(0, 0, 3'b000, 0, 1);
    tick(0, 0, 3'b000, 0, 0);
    tick(0, 0, 3'b000, 0, 0);
    tick(0, 0, 3'b000, 0, 1);
    repeat (3) tick(0, 0, 3'b000, 0, 0);
    chk("stall_bias", 64'(n_w[0] - b0[0]), 64'd2);
    chk("stall_addr", 64'(wr_addr), 64'd1);
    tick(0, 0, 3'b000, 1, 0);
    repeat (2) tick(0, 0, 3'b000, 0, 0);
    chk("stall_abort_busy", 64'(busy), 64'd0);

    // Mask skip
    snap();
    tick(0, 1, 3'b100, 0, 1);
    repeat (6) tick(0, 0, 3'b000, 0, 1);
    chk("skip_weight", 64'(n_w[2] - b0[2]), 64'd3);
    chk("skip_other", 64'(n_w[0] - b0[0] + n_w[1] - b0[1]), 64'd0);
    chk("skip_addr", 64'(wr_addr), 64'd2);

    snap();
    tick(0, 1, 3'b000, 0, 1);
    sc = cyc;
    repeat (3) tick(0, 0, 3'b000, 0, 1);
    chk("empty_latency", 64'(done_cyc - sc), 64'd1);
    chk("empty_writes",
        64'(n_w[0] + n_w[1] + n_w[2] - b0[0] - b0[1] - b0[2]), 64'd0);

    // Abort while taking ifmap word 1
    snap();
    tick(0, 1, 3'b010, 0, 1);
    tick(0, 0, 3'b000, 0, 1);
    tick(0, 0, 3'b000, 1, 1);
    repeat (3) tick(0, 0, 3'b000, 0, 1);
    chk("abort_ifmap", 64'(n_w[1] - b0[1]), 64'd1);
    chk("abort_done", 64'(n_done - d0), 64'd0);
    chk("abort_addr", 64'(wr_addr), 64'd0);

    // Abort together with start in idle: start wins
    snap();
    tick(0, 1, 3'b001, 1, 1);
    repeat (6) tick(0, 0, 3'b000, 0, 1);
    chk("abst_bias", 64'(n_w[0] - b0[0]), 64'd4);
    chk("abst_done", 64'(n_done - d0), 64'd1);

    // Reset mid weight, restart, start-while-busy ignored
    tick(0, 1, 3'b100, 0, 1);
    tick(0, 0, 3'b000, 0, 1);
    tick(0, 0, 3'b000, 0, 1);
    tick(1, 1, 3'b111, 1, 1);
    tick(0, 0, 3'b000, 0, 0);
    chk("rst_mid_busy", 64'(busy), 64'd0);
    chk("rst_mid_data", 64'(wr_data), 64'd0);
    snap();
    tick(0, 1, 3'b100, 0, 1);
    tick(0, 0, 3'b000, 0, 1);
    tick(0, 1, 3'b011, 0, 1);
    repeat (5) tick(0, 0, 3'b000, 0, 1);
    chk("restart_weight", 64'(n_w[2] - b0[2]), 64'd3);
    chk("restart_other", 64'(n_w[0] - b0[0] + n_w[1] - b0[1]), 64'd0);
    chk("restart_done", 64'(n_done - d0), 64'd1);

    tick(0, 0, 3'b000, 0, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/glb_load_sequencer.md
GLB_LOAD_SEQUENCER -- requirements
Module: glb_load_sequencer

Interface
REQ-001 Parameters, one per line (name, default, meaning):
- BIAS_WORDS, 64: words in the bias region.
- IFMAP_WORDS, 16: words in the ifmap region.
- WEIGHT_WORDS, 1024: words in the weight region.
- All three SHALL be in the range 1..1024.
REQ-002 Ports, one per line (name, direction, width, meaning):
- clk, input, 1: single clock.
- rst, input, 1: synchronous, active-high reset.
- start, input, 1: begin a load sequence.
- load_mask, input, 3: regions to load; bit0 bias, bit1 ifmap, bit2 weight.
- abort, input, 1: cancel the sequence in progress.
- ready, input, 1: DRAM word valid on data_in.
- data_in, input, 32: DRAM word.
- data_req, output, 1: sequencer accepts a word this cycle.
- bias_wen, output, 1: bias SRAM write enable.
- ifmap_wen, output, 1: ifmap SRAM write enable.
- weight_wen, output, 1: weight SRAM write enable.
- wr_addr, output, 10: SRAM word address.
- wr_data, output, 32: SRAM write data.
- busy, output, 1: sequence in progress.
- load_done, output, 1: one-cycle completion pulse.
REQ-003 There SHALL be one clock, clk; reset, rst, SHALL be synchronous and active-high.

Function
REQ-004 States SHALL be IDLE, BIAS, IFMAP, WEIGHT, DONE; the region order SHALL be fixed as bias, then ifmap, then weight.
REQ-005 In IDLE, start=1 SHALL latch load_mask and move to the first region whose mask bit is set; if no bit is set, the next state SHALL be DONE.
REQ-006 start SHALL be ignored when the state is not IDLE.
REQ-007 data_req SHALL be 1 in BIAS, IFMAP and WEIGHT, and 0 in IDLE and DONE.
REQ-008 A word SHALL be accepted on a cycle where data_req=1 and ready=1; ready=0 SHALL stall the sequencer with no state or counter change.
REQ-009 A word accepted at cycle t SHALL appear at cycle t+1:
- exactly one wen is high, the one for the accepting region;
- wr_data equals the accepted word;
- wr_addr equals the region word count before increment.
REQ-010 On cycles with no accepted word at t-1, all wen SHALL be 0 and wr_addr/wr_data SHALL hold their previous values.
REQ-011 The region word counter is 10 bits wide, SHALL reset to 0 on every region entry, and SHALL increment by 1 per accepted word.
REQ-012 When the word accepted in a region is count N-1 (N = that region's *_WORDS), the next state SHALL be the next enabled region, or DONE if none remains.
- The transition SHALL insert no bubble: data_req stays 1 across the region switch.
REQ-013 The counter SHALL never exceed N-1; with WEIGHT_WORDS=1024 the last address is 1023 and there SHALL be no wrap write.
REQ-014 DONE SHALL last exactly one cycle and then go to IDLE.
- load_done=1 only in DONE.
- The final region write occurs in the same cycle as DONE.
REQ-015 busy SHALL be 1 in every state except IDLE.
REQ-016 abort=1 in any non-IDLE state SHALL force IDLE at the next edge:
- no load_done pulse;
- a word accepted in the same cycle as abort SHALL NOT be written;
- a write already registered at the abort edge SHALL still issue.
- abort in IDLE SHALL have no effect.
REQ-017 If abort and start are asserted together in IDLE, start SHALL take effect.

Reset
REQ-018 While rst=1:
- state SHALL be IDLE;
- counter and latched mask SHALL be 0;
- data_req, all wen, busy and load_done SHALL be 0;
- wr_addr and wr_data SHALL be 0.
REQ-019 rst SHALL take priority over start and abort, including rst asserted mid-sequence; a pending registered write SHALL be dropped.

Verification
REQ-020 Full load:
- stimulus: mask=3'b111, BIAS_WORDS=4, IFMAP_WORDS=2, WEIGHT_WORDS=3, ready held at 1;
- response: bias_wen at addresses 0-3, then ifmap_wen at 0-1, then weight_wen at 0-2 on consecutive cycles, with data matching;
- load_done in the cycle of the final weight write;
- 11 cycles from start to load_done inclusive.
REQ-021 Stall:
- stimulus: ready toggling 1,0,0,1 in the bias region;
- response: exactly 2 bias writes at addresses 0 and 1, with no wen during the stall.
REQ-022 Mask skip:
- stimulus: mask=3'b100;
- response: only weight_wen is asserted, addresses 0..WEIGHT_WORDS-1;
- mask=3'b000 gives load_done the cycle after start and no writes.
REQ-023 Abort:
- stimulus: abort on the cycle accepting ifmap word 1;
- response: ifmap write of word 0 issues, word 1 is not written, no load_done, busy=0 the next cycle.
REQ-024 Reset and restart:
- rst mid-weight region gives all outputs 0 the next cycle;
- a later start reloads from address 0;
- start while busy is ignored and the mask is unchanged.
